// File: rtl/score_pkg.sv
// Shared widths, limits and types for the score display path.
package score_pkg;

    localparam int unsigned SCORE_W  = 17;
    localparam int unsigned N_DIGITS = 5;
    localparam int unsigned PTS_W    = 7;
    localparam int unsigned CNT_W    = $clog2(SCORE_W + 1);

    localparam logic [SCORE_W-1:0] SCORE_MAX = 17'd99999;

    typedef logic [3:0] bcd_t;
    typedef bcd_t [N_DIGITS-1:0] digits_t;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} conv_state_t;

    // Double-dabble correction: any nibble >= 5 would overflow past 9 after the next shift.
    function automatic digits_t bcd_adjust(input digits_t d);
        digits_t res;
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            res[i] = (d[i] >= 4'd5) ? d[i] + 4'd3 : d[i];
        end
        return res;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one LOAD cycle, SCORE_W shift cycles, one DONE cycle.
module bin2bcd_seq
    import score_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [SCORE_W-1:0] bin_in,
    output logic               busy,
    output logic               done,
    output digits_t            bcd_out
);

    conv_state_t               state_q;
    logic [SCORE_W-1:0]        shreg_q;
    digits_t                   bcd_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [4*N_DIGITS-1:0]     adj;

    assign adj     = bcd_adjust(bcd_q);
    assign bcd_out = bcd_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= LOAD;
                        busy    <= 1'b1;
                    end
                end
                LOAD: begin
                    shreg_q <= bin_in;
                    bcd_q   <= '0;
                    cnt_q   <= CNT_W'(SCORE_W);
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    bcd_q   <= {adj[4*N_DIGITS-2:0], shreg_q[SCORE_W-1]};
                    shreg_q <= {shreg_q[SCORE_W-2:0], 1'b0};
                    cnt_q   <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= DONE;
                        done    <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Saturating score accumulator with BCD conversion and frame-synchronous digit publishing.
module score_keeper
    import score_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pts_valid,
    input  logic [PTS_W-1:0]      pts,
    input  logic                  clear,
    input  logic                  frame_start,
    output logic [SCORE_W-1:0]    score,
    output logic [4*N_DIGITS-1:0] disp_digits,
    output logic                  busy,
    output logic                  saturated
);

    logic [SCORE_W:0] sum;
    logic             write;
    logic             start;
    logic             done;
    logic             dirty_q;
    logic             pending_fresh_q;
    digits_t          pending_q;
    digits_t          conv_bcd;

    assign sum   = {1'b0, score} + {{(SCORE_W + 1 - PTS_W){1'b0}}, pts};
    assign write = clear | pts_valid;
    assign start = dirty_q & ~busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            score     <= '0;
            saturated <= 1'b0;
            dirty_q   <= 1'b0;
        end else begin
            if (clear) begin
                score     <= '0;
                saturated <= 1'b0;
            end else if (pts_valid) begin
                if (sum > {1'b0, SCORE_MAX}) begin
                    score     <= SCORE_MAX;
                    saturated <= 1'b1;
                end else begin
                    score <= sum[SCORE_W-1:0];
                end
            end
            // A write in the start cycle must survive so the new value gets converted too.
            if (write) begin
                dirty_q <= 1'b1;
            end else if (start) begin
                dirty_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q       <= '0;
            pending_fresh_q <= 1'b0;
            disp_digits     <= '0;
        end else begin
            if (frame_start && pending_fresh_q) begin
                disp_digits     <= pending_q;
                pending_fresh_q <= 1'b0;
            end
            // A result landing on a frame_start cycle waits for the following frame.
            if (done) begin
                pending_q       <= conv_bcd;
                pending_fresh_q <= 1'b1;
            end
        end
    end

    bin2bcd_seq u_bin2bcd (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .bin_in  (score),
        .busy    (busy),
        .done    (done),
        .bcd_out (conv_bcd)
    );

endmodule

// File: tb/tb_score_keeper.sv
// Directed self-checking bench for score_keeper.
module tb_score_keeper;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pts_valid = 1'b0;
    logic [6:0]  pts = '0;
    logic        clear = 1'b0;
    logic        frame_start = 1'b0;
    logic [16:0] score;
    logic [19:0] disp_digits;
    logic        busy;
    logic        saturated;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    score_keeper dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pts_valid   (pts_valid),
        .pts         (pts),
        .clear       (clear),
        .frame_start (frame_start),
        .score       (score),
        .disp_digits (disp_digits),
        .busy        (busy),
        .saturated   (saturated)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [6:0] p);
        pts_valid = 1'b1;
        pts       = p;
        step();
        pts_valid = 1'b0;
        pts       = '0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    // Conversion activity is over once busy stays low for three samples.
    task automatic settle(input string tag);
        int quiet = 0;
        for (int i = 0; i < 400; i++) begin
            if (busy == 1'b0) quiet++;
            else quiet = 0;
            if (quiet >= 3) break;
            step();
        end
        check(tag, 32'(quiet >= 3), 32'd1);
    endtask

    task automatic wait_busy(input string tag, input logic level, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (busy == level) break;
            step();
        end
        check(tag, 32'(busy), 32'(level));
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_score", 32'(score), 32'd0);
        check("rst_disp", 32'(disp_digits), 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sat", 32'(saturated), 32'd0);
        #13 reset_n = 1'b1;
        step();
        pulse_frame();
        check("init_disp", 32'(disp_digits), 32'h0);
        check("init_score", 32'(score), 32'd0);
        check("init_busy", 32'(busy), 32'd0);

        // 754*90 + 30 = 67890
        for (int i = 0; i < 754; i++) add(7'd90);
        check("acc_partial", 32'(score), 32'd67860);
        add(7'd30);
        check("acc_score", 32'(score), 32'd67890);
        settle("acc_settle");
        check("acc_pre_frame", 32'(disp_digits), 32'h0);
        pulse_frame();
        check("acc_disp", 32'(disp_digits), 32'h67890);

        // Saturation: 787*127 + 41 = 99990
        do_clear();
        for (int i = 0; i < 787; i++) add(7'd127);
        add(7'd41);
        check("sat_base", 32'(score), 32'd99990);
        add(7'd9);
        check("sat_exact_score", 32'(score), 32'd99999);
        check("sat_exact_flag", 32'(saturated), 32'd0);
        add(7'd50);
        check("sat_clip_score", 32'(score), 32'd99999);
        check("sat_clip_flag", 32'(saturated), 32'd1);
        add(7'd0);
        check("sat_zero_add", 32'(score), 32'd99999);
        check("sat_sticky", 32'(saturated), 32'd1);
        settle("sat_settle");
        pulse_frame();
        check("sat_disp", 32'(disp_digits), 32'h99999);
        do_clear();
        check("clr_score", 32'(score), 32'd0);
        check("clr_sat", 32'(saturated), 32'd0);

        // clear beats pts_valid: 3*127 + 119 = 500
        add(7'd127); add(7'd127); add(7'd127); add(7'd119);
        check("prio_base", 32'(score), 32'd500);
        pts_valid = 1'b1;
        pts       = 7'd5;
        clear     = 1'b1;
        step();
        pts_valid = 1'b0;
        clear     = 1'b0;
        check("prio_score", 32'(score), 32'd0);
        settle("prio_settle");
        check("prio_pre_frame", 32'(disp_digits), 32'h99999);
        pulse_frame();
        check("prio_disp", 32'(disp_digits), 32'h0);

        // Score change mid-conversion triggers a reconversion
        add(7'd12);
        wait_busy("mid_start", 1'b1, 5);
        for (int i = 0; i < 5; i++) step();
        add(7'd1);
        check("mid_score", 32'(score), 32'd13);
        wait_busy("mid_first_done", 1'b0, 40);
        pulse_frame();
        check("mid_first_disp", 32'(disp_digits), 32'h00012);
        check("mid_reconvert", 32'(busy), 32'd1);
        settle("mid_settle");
        check("mid_hold", 32'(disp_digits), 32'h00012);
        pulse_frame();
        check("mid_second_disp", 32'(disp_digits), 32'h00013);
        pulse_frame();
        check("mid_no_fresh", 32'(disp_digits), 32'h00013);

        // Reset mid-conversion: 34*127 + 3 = 4321
        do_clear();
        for (int i = 0; i < 34; i++) add(7'd127);
        add(7'd3);
        settle("rstmid_settle");
        pulse_frame();
        check("rstmid_disp", 32'(disp_digits), 32'h04321);
        add(7'd0);
        wait_busy("zero_add_dirty", 1'b1, 5);
        for (int i = 0; i < 4; i++) step();
        #2 reset_n = 1'b0;
        #1;
        check("arst_score", 32'(score), 32'd0);
        check("arst_disp", 32'(disp_digits), 32'h0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_sat", 32'(saturated), 32'd0);
        #3 reset_n = 1'b1;
        for (int i = 0; i < 25; i++) step();
        check("post_busy", 32'(busy), 32'd0);
        pulse_frame();
        check("post_disp", 32'(disp_digits), 32'h0);
        add(7'd5);
        settle("post_settle");
        pulse_frame();
        check("post_new_disp", 32'(disp_digits), 32'h00005);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
Producer side of the score display path. Accumulates game points into a saturating binary score and converts it to five BCD digits with a sequential double-dabble engine. Publishes the digits to the VGA score renderer only at frame boundaries, so a frame never shows a half-updated score. Sits between game logic and the score/digit rendering blocks; the renderer consumes `disp_digits` and never sees the binary value.

Parameters:
- SCORE_W, 17, width of binary score (holds 0..99999)
- N_DIGITS, 5, number of BCD digits published
- PTS_W, 7, width of per-event point increment

Ports:
- clk, input, 1, system clock (pixel-domain clock)
- reset_n, input, 1, reset, asynchronous, active-low
- pts_valid, input, 1, one-cycle strobe: add pts to score
- pts, input, PTS_W, points to add when pts_valid=1
- clear, input, 1, synchronous score clear (new game)
- frame_start, input, 1, one-cycle pulse at start of vertical blank
- score, output, SCORE_W, current binary score
- disp_digits, output, 4*N_DIGITS, published BCD digits, [19:16]=ten-thousands … [3:0]=units
- busy, output, 1, conversion engine not IDLE
- saturated, output, 1, sticky: an add was clipped at 99999

Behaviour:
- Reset (async, reset_n=0): score=0, disp_digits=0, busy=0, saturated=0, FSM=IDLE, dirty=0, pending=0, pending_fresh=0.
- Accumulate: sum computed at SCORE_W+1 bits; score <= (sum > 99999) ? 99999 : sum; saturated set when clipped.
- clear wins over pts_valid in the same cycle: score<=0, saturated<=0, dirty<=1.
- pts_valid with pts=0 leaves score unchanged and still sets dirty.
- dirty is set on any score write and cleared when the FSM leaves IDLE.
- If a score write and an FSM start happen in the same cycle, dirty stays 1.
- FSM states:
  - IDLE: if dirty, go to LOAD.
  - LOAD (1 cycle): snapshot score into shift register; BCD accumulator <= 0; bit count <= SCORE_W.
  - SHIFT (SCORE_W=17 cycles): add 3 to each BCD nibble >= 5, then shift left one bit.
  - DONE (1 cycle): pending <= BCD result; pending_fresh <= 1; go to IDLE.
- Latency from dirty seen in IDLE to pending_fresh=1 is 19 cycles.
- busy=1 in LOAD, SHIFT and DONE.
- Score changes during a conversion do not abort it. The snapshot stays consistent, and dirty causes a reconversion after DONE.
- Publish: on frame_start with pending_fresh=1, disp_digits <= pending and pending_fresh <= 0. The update is visible the cycle after frame_start.
  - frame_start with pending_fresh=0: no change.
  - frame_start in the DONE cycle sees the old pending_fresh; the new value is published at the next frame_start.
- disp_digits never changes except on frame_start or reset.
- Reset mid-conversion returns everything to reset values immediately.

Decomposition:
- Package score_pkg holds:
  - SCORE_W, N_DIGITS, PTS_W
  - SCORE_MAX=17'd99999
  - typedef `bcd_t` (logic[3:0])
  - typedef `digits_t` (`bcd_t` [N_DIGITS-1:0])
  - enum `conv_state_t` {IDLE, LOAD, SHIFT, DONE}
- Sub-module bin2bcd_seq holds the FSM and shift/add-3 datapath.
  - Interface: start/busy/done/bin_in/bcd_out.
  - score_keeper keeps the accumulator, dirty flag and publish register.

Test Plan:
- Reset, then frame_start -> disp_digits=0x00000, score=0, busy=0.
- pts_valid pts=90 ×754 then pts=30, wait 19 cycles, pulse frame_start -> score=67890, disp_digits=0x67890 one cycle after the pulse, unchanged before it.
- score=99990, pts_valid pts=50 -> score=99999, saturated=1. After conversion and frame_start, disp_digits=0x99999. Then clear -> saturated=0, score=0.
- pts_valid and clear in the same cycle with score=500 -> score=0; published digits after next frame_start = 0x00000.
- Start conversion at score=12; 5 cycles later add pts=1 -> first DONE gives pending 0x00012, busy stays 1 for a second conversion. Frame_start after the second DONE -> 0x00013.
- Deassert reset_n during SHIFT at score=4321 -> outputs zero asynchronously. After release, busy=0 and disp_digits=0 until a new score write plus frame_start.
